inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
// Instruction buffer between IFU and decoder_stage. Accepts fetch groups of up to 4
// instructions (sparse slot mask), compacts them in slot order, and stores them in a
// circular FIFO. Presents the 4 oldest entries as a dense group (instr_0..3, fetch_valid,
// ifu_valid) to decoder_stage. Decouples IFU stalls from decode back-pressure.
// PARAMETERS
// DEPTH   16   queue entries; power of two, >= 8
// FW      4    fetch/decode width; fixed at 4 (decoder_stage is 4-wide)
// PORTS
// clk            in   1      clock
// rst_n          in   1      reset, asynchronous, active-low
// flush          in   1      synchronous pipeline flush
// in_valid       in   1      IFU offers a fetch group
// in_ready       out  1      queue accepts a group this cycle
// in_instr[0:3]  in   4x32   fetched instruction words, slot 0 = lowest address
// in_mask        in   4      per-slot valid; may be sparse (e.g. 4'b1100)
// in_pc          in   32     PC of slot 0; slot i PC = in_pc + 4*i
// ifu_valid      out  1      group presented to decoder (count != 0)
// instr_0..3     out  32     oldest 4 entries, instr_0 oldest
// pc_0..3        out  32     PCs matching instr_0..3
// fetch_valid    out  4      dense thermometer mask (4'b0001/0011/0111/1111)
// decoder_ready  in   1      decoder_stage accepts the presented group
// BEHAVIOUR
// - State: entry array {instr,pc} x DEPTH, head/tail ptr [$clog2(DEPTH)-1:0] (wrap mod
//   DEPTH), count [$clog2(DEPTH):0]. Only the control state is reset; the array is not.
// - Reset: head=tail=count=0 -> ifu_valid=0, fetch_valid=0, in_ready=1, instr_*/pc_*=0.
// - in_ready = (DEPTH - count >= 4), from registered count only. There is no
//   combinational path from decoder_ready or flush.
// - Push: in_valid && in_ready && !flush. push_n = popcount(in_mask), range 0..4. Set
//   slots are written in ascending slot order at tail, tail+1, ... (wrapping).
//   tail += push_n. in_mask=0 is accepted as a no-op.
// - Output (combinational from registers): avail = min(count,4); slot k (k<avail) is entry
//   head+k (wrapping); fetch_valid = (1<<avail)-1; ifu_valid = (count!=0). Slots k>=avail
//   drive instr_k=0, pc_k=0.
// - Pop: ifu_valid && decoder_ready && !flush. pop_n = avail, so the whole presented group
//   is consumed at once. head += pop_n.
// - Simultaneous push+pop: count_next = count + push_n - pop_n. A push may write entries
//   freed by the same-cycle pop only when in_ready was already 1 (no bypass).
// - Latency: an instruction pushed in cycle N appears on the outputs in cycle N+1 at the
//   earliest. No bypass from in_* to outputs.
// - Flush: head=tail=count=0 next cycle. Push and pop in the flush cycle are discarded.
//   Outputs go to their reset values in the following cycle.
// - Full (count > DEPTH-4): in_ready=0 and the IFU holds. Empty: ifu_valid=0 and
//   decoder_ready is ignored.
// - Invariant: count <= DEPTH always. An overflow is an assertion failure.
// - Reset mid-operation: asynchronous clear of pointers/count. Outputs go invalid at once.
// STRUCTURE
// - Shared package (mycpu pkg): FETCH_WIDTH=4, IFQ_DEPTH default, typedef ifq_entry_t
//   {logic[31:0] instr; logic[31:0] pc;}.
// - Sub-module ifq_compactor (combinational): in_mask, in_instr, in_pc -> dense entries
//   [0:3] + push_n. The top level holds the pointers, array, and handshake.
// - Assertions: no push when !in_ready, count <= DEPTH, fetch_valid always a thermometer.
// TESTING
// 1 Reset, then push mask 4'b1111, instr A0..A3, pc 0x1C000000 -> next cycle ifu_valid=1,
//   fetch_valid=4'b1111, pc_3=0x1C00000C.
// 2 Push mask 4'b1100 (B2,B3, pc 0x100) with decoder_ready=0 -> instr_0=B2, pc_0=0x108,
//   instr_1=B3, fetch_valid=4'b0011.
// 3 decoder_ready=0, push 4 full groups -> count=16, in_ready=0. A further in_valid is
//   ignored and count stays 16.
// 4 Wrap: DEPTH=16, pointers at 14, push 4 -> entries at 14,15,0,1. Outputs stay in order
//   after popping past the wrap.
// 5 count=2, decoder_ready=1 with push of 3 in the same cycle -> pop 2, count_next=3,
//   fetch_valid=4'b0111.
// 6 flush with in_valid=1 and decoder_ready=1 -> next cycle count=0, ifu_valid=0,
//   in_ready=1. The flushed group never appears.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   FETCH_WIDTH : fetch/decode group width (decoder_stage is 4-wide)
//   IFQ_DEPTH   : default number of queue entries
//   ifq_entry_t : one queued instruction word with its PC
//   is_thermo   : true when a 4-bit group mask is a dense low-aligned thermometer
package inst_fetch_queue_pkg;

  localparam int FETCH_WIDTH = 4;
  localparam int IFQ_DEPTH   = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifq_entry_t;

  function automatic logic is_thermo(input logic [3:0] mask);
    return (mask == 4'b0000) || (mask == 4'b0001) || (mask == 4'b0011) ||
           (mask == 4'b0111) || (mask == 4'b1111);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_chk.sv
// Property checker for the instruction fetch queue control state.
//   push        : a group is being written this cycle
//   in_ready    : queue advertises room for a full group
//   count       : registered occupancy
//   fetch_valid : mask presented to the decoder
module inst_fetch_queue_chk
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic             in_ready,
  input logic [CNT_W-1:0] count,
  input logic [3:0]       fetch_valid
);

  // A write may only happen while room for a full group was advertised.
  a_push_needs_ready: assert property (@(posedge clk) disable iff (!rst_n) push |-> in_ready);

  // Occupancy can never exceed the storage.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_W'(DEPTH));

  // The decoder always sees a dense, low-aligned group.
  a_thermo: assert property (@(posedge clk) disable iff (!rst_n) is_thermo(fetch_valid));

endmodule

// File: rtl/inst_fetch_queue_compactor.sv
// Combinational compactor: squeezes a sparse fetch group into dense slots.
//   in_mask  : per-slot valid bits (may be sparse)
//   in_instr : slot instruction words, slot 0 = lowest address
//   in_pc    : PC of slot 0; slot i sits at in_pc + 4*i
//   entries  : dense {instr,pc} list, set slots in ascending slot order
//   push_n   : number of set slots (0..4)
module ifq_compactor
  import inst_fetch_queue_pkg::*;
(
  input  logic [3:0]  in_mask,
  input  logic [31:0] in_instr [FETCH_WIDTH],
  input  logic [31:0] in_pc,
  output ifq_entry_t  entries  [FETCH_WIDTH],
  output logic [2:0]  push_n
);

  logic [2:0] idx_s;

  // Walk the slots in order and append each valid one at the next dense index.
  always_comb begin
    idx_s = 3'd0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      entries[k] = '0;
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (in_mask[i]) begin
        entries[idx_s[1:0]].instr = in_instr[i];
        entries[idx_s[1:0]].pc    = in_pc + 32'(4 * i);
        idx_s = idx_s + 3'd1;
      end else begin
        idx_s = idx_s;
      end
    end
    push_n = idx_s;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the IFU and decoder_stage.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous pipeline flush (drops everything)
//   in_valid/in_ready    : IFU group handshake; in_ready = room for 4 entries
//   in_instr/in_mask/in_pc : sparse fetch group, slot 0 at in_pc
//   ifu_valid            : at least one entry presented
//   instr_0..3, pc_0..3  : oldest four entries, instr_0 oldest, zero when unused
//   fetch_valid          : dense thermometer of valid presented slots
//   decoder_ready        : decoder consumes the whole presented group
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr [0:3],
  input  logic [3:0]  in_mask,
  input  logic [31:0] in_pc,
  output logic        ifu_valid,
  output logic [31:0] instr_0,
  output logic [31:0] instr_1,
  output logic [31:0] instr_2,
  output logic [31:0] instr_3,
  output logic [31:0] pc_0,
  output logic [31:0] pc_1,
  output logic [31:0] pc_2,
  output logic [31:0] pc_3,
  output logic [3:0]  fetch_valid,
  input  logic        decoder_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_r, tail_r;
  logic [CNT_W-1:0] count_r, count_next_s;
  ifq_entry_t       mem_r   [DEPTH];
  ifq_entry_t       dense_s [FETCH_WIDTH];
  ifq_entry_t       out_s   [FETCH_WIDTH];
  logic [2:0]       push_n_s, avail_s;
  logic             push_s, pop_s;

  ifq_compactor u_compactor (
    .in_mask  (in_mask),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .entries  (dense_s),
    .push_n   (push_n_s)
  );

  // Ready depends on registered occupancy only, so a same-cycle pop never frees room.
  assign in_ready  = (count_r <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign ifu_valid = (count_r != {CNT_W{1'b0}});
  assign push_s    = in_valid & in_ready & ~flush;
  assign pop_s     = ifu_valid & decoder_ready & ~flush;

  // Number of entries presented to the decoder: min(count, 4).
  always_comb begin
    if (count_r >= CNT_W'(FETCH_WIDTH)) begin
      avail_s = 3'd4;
    end else begin
      avail_s = count_r[2:0];
    end
  end

  // Next occupancy from the accepted push and the consumed group.
  always_comb begin
    count_next_s = count_r;
    if (push_s) begin
      count_next_s = count_next_s + CNT_W'(push_n_s);
    end else begin
      count_next_s = count_next_s;
    end
    if (pop_s) begin
      count_next_s = count_next_s - CNT_W'(avail_s);
    end else begin
      count_next_s = count_next_s;
    end
  end

  // Control state: pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + PTR_W'(push_n_s);
      if (pop_s)  head_r <= head_r + PTR_W'(avail_s);
      count_r <= count_next_s;
    end
  end

  // Entry storage is data-only and intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (3'(k) < push_n_s) mem_r[tail_r + PTR_W'(k)] <= dense_s[k];
      end
    end
  end

  // Present the oldest entries; unused slots are forced to zero.
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (3'(k) < avail_s) begin
        out_s[k] = mem_r[head_r + PTR_W'(k)];
      end else begin
        out_s[k] = '0;
      end
    end
  end

  // Thermometer mask of presented slots.
  always_comb begin
    case (avail_s)
      3'd0:    fetch_valid = 4'b0000;
      3'd1:    fetch_valid = 4'b0001;
      3'd2:    fetch_valid = 4'b0011;
      3'd3:    fetch_valid = 4'b0111;
      default: fetch_valid = 4'b1111;
    endcase
  end

  assign instr_0 = out_s[0].instr;
  assign instr_1 = out_s[1].instr;
  assign instr_2 = out_s[2].instr;
  assign instr_3 = out_s[3].instr;
  assign pc_0    = out_s[0].pc;
  assign pc_1    = out_s[1].pc;
  assign pc_2    = out_s[2].pc;
  assign pc_3    = out_s[3].pc;

  inst_fetch_queue_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_s),
    .in_ready    (in_ready),
    .count       (count_r),
    .fetch_valid (fetch_valid)
  );

endmodule
